// File: rtl/rv_pkg.sv
// rv_pkg: RV32I opcode constants, format classification and range helper
// shared by the instruction encoder/loader.
package rv_pkg;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R, FMT_BAD} fmt_e;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FIN} state_e;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
      OP_STORE:                 return FMT_S;
      OP_BRANCH:                return FMT_B;
      OP_REG:                   return FMT_R;
      OP_LUI, OP_AUIPC:         return FMT_U;
      OP_JAL:                   return FMT_J;
      default:                  return FMT_BAD;
    endcase
  endfunction

  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return $signed(v) >= lo && $signed(v) <= hi;
  endfunction
endpackage

// File: rtl/rv_pack.sv
// rv_pack: combinational RV32I field packer; illegal encodings come out as NOP
// with err raised so the loader keeps its slot count and address sequence.
module rv_pack import rv_pkg::*; (
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err
);
  fmt_e        fmt;
  logic        shift;
  logic [31:0] raw;
  always_comb begin
    fmt   = fmt_of(opcode);
    shift = opcode == OP_IMM && funct3[1:0] == 2'b01;
    raw   = NOP;
    case (fmt)
      FMT_I:   raw = shift ? {1'b0, funct7, 5'b0, imm[4:0], rs1, funct3, rd, opcode}
                           : {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   raw = {imm[31:12], rd, opcode};
      FMT_J:   raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      FMT_R:   raw = {1'b0, funct7, 5'b0, rs2, rs1, funct3, rd, opcode};
      default: raw = NOP;
    endcase
    err = fmt == FMT_BAD
       || ((fmt == FMT_I || fmt == FMT_S) && !in_range(imm, -2048, 2047))
       || (fmt == FMT_B && (imm[0] || !in_range(imm, -4096, 4094)))
       || (fmt == FMT_J && (imm[0] || !in_range(imm, -1048576, 1048574)));
    word = err ? NOP : raw;
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts decoded RV32I field bundles, encodes them and
// streams the words into instruction memory at consecutive word addresses.
module instr_encoder_loader import rv_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, acc_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, enc_word;
  logic              we_q, err_q, enc_err, xfer, drain, last;

  rv_pack u_pack (
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
    .rs2(rs2), .imm(imm), .word(enc_word), .err(enc_err)
  );

  assign drain = we_q & mem_ready;
  assign last  = drain && (wr_q + CNT_ONE == cnt_q);
  assign xfer  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ST_IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && count != '0) state_d = ST_LOAD;
               else if (start) state_d = ST_FIN;
      ST_LOAD: if (last) state_d = ST_FIN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = state_q == ST_LOAD && acc_q < cnt_q && (!we_q || mem_ready);
    busy      = state_q != ST_IDLE;
    done      = state_q == ST_FIN;
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    err       = err_q;
  end

  // An accept in the same cycle as a drain overwrites the output register,
  // giving one word per cycle without a second buffer.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      wr_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      cnt_q  <= count;
      acc_q  <= '0;
      wr_q   <= '0;
      err_q  <= 1'b0;
      addr_q <= base_addr & ~ADDR_W'(3);
    end else begin
      if (xfer) begin
        acc_q   <= acc_q + CNT_ONE;
        wdata_q <= enc_word;
        err_q   <= err_q | enc_err;
      end
      if (drain) begin
        wr_q   <= wr_q + CNT_ONE;
        addr_q <= addr_q + ADDR_W'(4);
      end
      we_q <= xfer | (we_q & ~mem_ready);
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: randomized scoreboard bench; expected writes are queued
// at accept time and checked by an independent write monitor.
module tb_instr_encoder_loader;
  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7;
    logic [4:0] rd, rs1, rs2; logic [31:0] imm;
    logic [31:0] word; logic bad;
  } instr_t;
  typedef struct {logic [31:0] addr; logic [31:0] word;} wr_t;

  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, funct7 = 0, mem_ready = 1;
  logic [31:0] base_addr = 0, imm = 0;
  logic [15:0] count = 0;
  logic [6:0]  opcode = 0;
  logic [2:0]  funct3 = 0;
  logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
  logic        in_ready, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;

  int checks = 0, errors = 0, remaining = 0;
  wr_t    exp_q[$];
  instr_t stim[$];
  logic   done_arm = 0, err_m = 0, prev_stall = 0;
  logic [31:0] prev_addr = 0, prev_data = 0;

  always #5 clk = ~clk;

  instr_encoder_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endfunction

  // Reference encoder: field placement by multiply/shift/modulo arithmetic
  function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic [4:0] rd_, input logic [4:0] rs1_,
                                input logic [4:0] rs2_, input logic [31:0] im);
    instr_t t;
    longint si;
    logic [31:0] r, a, b, f, s7, o;
    si = longint'($signed(im));
    r = 32'(rd_) << 7; a = 32'(rs1_) << 15; b = 32'(rs2_) << 20;
    f = 32'(f3) << 12; s7 = 32'(f7) << 30; o = 32'(op);
    t.op = op; t.f3 = f3; t.f7 = f7; t.rd = rd_; t.rs1 = rs1_; t.rs2 = rs2_; t.imm = im;
    t.bad = 0; t.word = 0;
    case (op)
      7'h13, 7'h03, 7'h67: begin
        t.bad = si < -2048 || si > 2047;
        t.word = (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5))
               ? (s7 | ((im % 32) << 20) | a | f | r | o)
               : (((im % 4096) << 20) | a | f | r | o);
      end
      7'h23: begin
        t.bad = si < -2048 || si > 2047;
        t.word = (((im >> 5) % 128) << 25) | b | a | f | ((im % 32) << 7) | o;
      end
      7'h63: begin
        t.bad = im[0] || si < -4096 || si > 4094;
        t.word = (((im >> 12) % 2) << 31) | (((im >> 5) % 64) << 25) | b | a | f
               | (((im >> 1) % 16) << 8) | (((im >> 11) % 2) << 7) | o;
      end
      7'h33: t.word = s7 | b | a | f | r | o;
      7'h37, 7'h17: t.word = ((im / 4096) * 4096) | r | o;
      7'h6F: begin
        t.bad = im[0] || si < -1048576 || si > 1048574;
        t.word = (((im >> 20) % 2) << 31) | (((im >> 1) % 1024) << 21)
               | (((im >> 11) % 2) << 20) | (((im >> 12) % 256) << 12) | r | o;
      end
      default: t.bad = 1;
    endcase
    if (t.bad) t.word = 32'h13;
    return t;
  endfunction

  function automatic instr_t rnd();
    logic [6:0] ops[10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h7F};
    logic [31:0] im;
    int k;
    k = $urandom_range(0, 3);
    im = k == 0 ? 32'($urandom_range(0, 4200)) - 32'd2100
       : k == 1 ? (32'($urandom_range(0, 2300000)) - 32'd1150000) & ~32'd1
       : k == 2 ? (32'($urandom_range(0, 9000)) - 32'd4500) & ~32'd1 : $urandom;
    return mk(ops[$urandom_range(0, 9)], 3'($urandom), 1'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom), im);
  endfunction

  task automatic push_dir(input instr_t t, input logic [31:0] w, input logic b);
    t.word = w;
    t.bad = b;
    stim.push_back(t);
  endtask

  // mode 0: always valid/ready, 1: random valid/ready, 2: ready held low 3 cycles
  task automatic run_load(input logic [31:0] base, input int n, input int mode);
    int idx = 0, cyc = 0, stall = 0;
    logic acc = 0, seen = 0;
    logic [31:0] waddr;
    waddr = base & 32'hFFFF_FFFC;
    @(posedge clk); #1;
    start = 1; base_addr = base; count = 16'(n);
    @(posedge clk); #1;
    start = 0; err_m = 0; remaining = n;
    if (n == 0) done_arm = 1;
    while (!seen && cyc < 500) begin
      in_valid = idx < n && (mode != 1 || $urandom_range(0, 3) != 0);
      if (idx < n) begin
        opcode = stim[idx].op; funct3 = stim[idx].f3; funct7 = stim[idx].f7;
        rd = stim[idx].rd; rs1 = stim[idx].rs1; rs2 = stim[idx].rs2; imm = stim[idx].imm;
      end
      if (mode == 1) mem_ready = $urandom_range(0, 2) != 0;
      else if (mode == 2 && mem_we && stall < 3) begin mem_ready = 0; stall++; end
      else mem_ready = 1;
      @(negedge clk);
      if (cyc == 0) begin
        chk("err_clear_on_start", err, 0);
        chk("busy_after_start", busy, 1);
      end
      if (acc) chk("we_latency", mem_we, 1);
      if (mode == 0 && idx < n) chk("in_ready_b2b", in_ready, 1);
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back('{waddr, stim[idx].word});
        err_m = err_m | stim[idx].bad;
        waddr += 4;
        idx++;
      end
      seen = done;
      @(posedge clk); #1;
      cyc++;
    end
    if (!seen) chk("done_timeout", 0, 1);
    in_valid = 0; mem_ready = 1;
    chk("err_final", err, err_m);
    chk("idle_after_done", busy, 0);
    chk("drained", exp_q.size(), 0);
    repeat (n) void'(stim.pop_front());
  endtask

  always @(negedge clk) begin
    logic exp_done;
    wr_t w;
    if (!rst_n) begin
      prev_stall = 0;
      done_arm = 0;
    end else begin
      exp_done = done_arm;
      done_arm = 0;
      if (done || exp_done) chk("done_pulse", done, exp_done);
      if (done) chk("done_without_we", mem_we, 0);
      if (prev_stall) begin
        chk("hold_we", mem_we, 1);
        chk("hold_addr", mem_addr, prev_addr);
        chk("hold_wdata", mem_wdata, prev_data);
      end
      if (mem_we && !mem_ready) chk("stall_in_ready", in_ready, 0);
      if (mem_we && mem_ready) begin
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          w = exp_q.pop_front();
          chk("mem_addr", mem_addr, w.addr);
          chk("mem_wdata", mem_wdata, w.word);
          remaining--;
          if (remaining == 0) done_arm = 1;
        end
      end
      prev_stall = mem_we && !mem_ready;
      prev_addr = mem_addr;
      prev_data = mem_wdata;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    #12 chk_zero("reset");
    #10 rst_n = 1;

    push_dir(mk(7'h13, 0, 0, 1, 0, 0, 5), 32'h0050_0093, 0);
    run_load(32'h100, 1, 0);

    push_dir(mk(7'h23, 2, 0, 0, 1, 2, 8), 32'h0020_A423, 0);
    push_dir(mk(7'h6F, 0, 0, 1, 0, 0, 8), 32'h0080_00EF, 0);
    push_dir(mk(7'h37, 0, 0, 5, 0, 0, 32'h1234_5000), 32'h1234_52B7, 0);
    push_dir(mk(7'h33, 0, 1, 3, 1, 2, 0), 32'h4020_81B3, 0);
    run_load(32'h0, 4, 0);

    push_dir(mk(7'h13, 5, 1, 4, 1, 0, 3), 32'h4030_D213, 0);
    run_load(32'h2000, 1, 2);

    push_dir(mk(7'h63, 0, 0, 0, 1, 2, 3), 32'h0000_0013, 1);
    push_dir(mk(7'h7F, 0, 0, 1, 2, 3, 0), 32'h0000_0013, 1);
    run_load(32'h300, 2, 0);

    repeat (3) stim.push_back(rnd());
    run_load(32'h400, 3, 1);

    repeat (2) stim.push_back(rnd());
    run_load(32'hFFFF_FFFC, 2, 1);

    run_load(32'h500, 0, 0);

    repeat (3) stim.push_back(rnd());
    @(posedge clk); #1;
    start = 1; base_addr = $urandom; count = 3;
    @(posedge clk); #1;
    start = 0; in_valid = 1; mem_ready = 0;
    opcode = stim[0].op; funct3 = stim[0].f3; funct7 = stim[0].f7;
    rd = stim[0].rd; rs1 = stim[0].rs1; rs2 = stim[0].rs2; imm = stim[0].imm;
    @(posedge clk); #1;
    in_valid = 0;
    #2 rst_n = 0;
    #1 chk_zero("midload_reset");
    exp_q.delete(); stim.delete(); remaining = 0;
    @(negedge clk); rst_n = 1; mem_ready = 1;

    for (int i = 0; i < 25; i++) begin
      int n;
      n = $urandom_range(1, 8);
      repeat (n) stim.push_back(rnd());
      run_load($urandom, n, $urandom_range(0, 1));
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
